// File: rtl/trng_harvest_ctrl_pkg.sv
// Shared types and defaults for the TRNG harvest controller.
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        FILL   = 3'd2,
        FULL   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_REP     = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam int WORD_W_DEF      = 8;
    localparam int WARMUP_BITS_DEF = 16;
    localparam int REP_LIMIT_DEF   = 32;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/trng_harvest_ctrl_rep_test.sv
// Repetition-count health test: flags the accepted bit that completes a run of REP_LIMIT equal bits.
module trng_rep_test
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic accept,
    input  logic bit_in,
    output logic rep_fail
);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       last_bit;

    always_comb begin
        cnt_nxt = 8'd1;
        if (cnt != 8'd0 && bit_in == last_bit) begin
            cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
    end

    // Combinational so the failing bit can pre-empt a word completing on the same cycle.
    assign rep_fail = accept && (cnt_nxt >= 8'(REP_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt      <= 8'd0;
            last_bit <= 1'b0;
        end else if (accept) begin
            cnt      <= cnt_nxt;
            last_bit <= bit_in;
        end
    end

endmodule

// File: rtl/trng_harvest_ctrl.sv
// Von Neumann extractor sequencer: warm-up discard, word packing, valid/ready delivery, health tests.
// Optional build macro TRNG_CTRL_STATS_EN adds the word_cnt handshake counter output.
module trng_harvest_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int WARMUP_BITS = WARMUP_BITS_DEF,
    parameter int REP_LIMIT   = REP_LIMIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_fault,
    input  logic              extr_bit,
    input  logic              extr_valid,
    output logic              extr_en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
`ifdef TRNG_CTRL_STATS_EN
    ,
    output logic [15:0]       word_cnt
`endif
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int WU_W = (WARMUP_BITS < 2) ? 1 : $clog2(WARMUP_BITS);
    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [WU_W-1:0] WARM_LAST = WU_W'((WARMUP_BITS > 0) ? WARMUP_BITS - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t            state;
    logic              en_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_nxt;
    logic [BC_W-1:0]   bit_cnt;
    logic [WU_W-1:0]   warm_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              accept;
    logic              acc_h;
    logic              hs;
    logic              out_free;
    logic              rep_fail;
    logic              to_fail;

    // The extractor's valid is stale until it has been enabled for a cycle, hence en_q.
    assign accept    = extr_valid && en_q;
    assign acc_h     = accept && (state == WARMUP || state == FILL);
    assign hs        = rnd_valid && rnd_ready;
    assign out_free  = !rnd_valid || rnd_ready;
    assign shift_nxt = {shift_q[WORD_W-2:0], extr_bit};
    assign to_fail   = extr_en && !accept && (to_cnt == TO_LAST);

    trng_rep_test #(
        .REP_LIMIT(REP_LIMIT)
    ) u_rep_test (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == FAULT && clear_fault),
        .accept  (acc_h),
        .bit_in  (extr_bit),
        .rep_fail(rep_fail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            extr_en    <= 1'b0;
            busy       <= 1'b0;
            en_q       <= 1'b0;
            rnd_valid  <= 1'b0;
            rnd_data   <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            warm_cnt   <= '0;
            to_cnt     <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            en_q <= extr_en;
            if (!extr_en || accept) to_cnt <= '0;
            else                    to_cnt <= to_cnt + 1'b1;
            if (hs) rnd_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= (WARMUP_BITS == 0) ? FILL : WARMUP;
                        extr_en  <= 1'b1;
                        busy     <= 1'b1;
                        warm_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                WARMUP, FILL: begin
                    // Health failures win over stop and over a word completing this cycle.
                    if (rep_fail || to_fail) begin
                        state      <= FAULT;
                        extr_en    <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= rep_fail ? FC_REP : FC_TIMEOUT;
                        rnd_valid  <= 1'b0;
                        shift_q    <= '0;
                    end else if (!start) begin
                        state   <= IDLE;
                        extr_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (acc_h) begin
                        if (state == WARMUP) begin
                            if (warm_cnt == WARM_LAST) begin
                                state   <= FILL;
                                bit_cnt <= '0;
                            end else begin
                                warm_cnt <= warm_cnt + 1'b1;
                            end
                        end else begin
                            shift_q <= shift_nxt;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                if (out_free) begin
                                    rnd_data  <= shift_nxt;
                                    rnd_valid <= 1'b1;
                                end else begin
                                    state   <= FULL;
                                    extr_en <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (!start) begin
                        state   <= IDLE;
                        extr_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (hs) begin
                        rnd_data  <= shift_q;
                        rnd_valid <= 1'b1;
                        state     <= FILL;
                        extr_en   <= 1'b1;
                    end
                end
                FAULT: begin
                    rnd_valid <= 1'b0;
                    shift_q   <= '0;
                    if (clear_fault) begin
                        state      <= IDLE;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        bit_cnt    <= '0;
                        warm_cnt   <= '0;
                        to_cnt     <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    extr_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRNG_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)     word_cnt <= '0;
        else if (hs) word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Directed bench for trng_harvest_ctrl: cycle table for warm-up/first word, hand sequences for corner cases.
module tb_trng_harvest_ctrl;
    import trng_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, clear_fault, extr_bit, extr_valid, rnd_ready;
    logic       extr_en, rnd_valid, busy, fault;
    logic [7:0] rnd_data;
    logic [1:0] fault_code;
    int         n_chk = 0;
    int         n_fail = 0;
`ifdef TRNG_CTRL_STATS_EN
    logic [15:0] word_cnt;
`endif

    always #5 clk = ~clk;

    trng_harvest_ctrl #(
        .WORD_W(8), .WARMUP_BITS(4), .REP_LIMIT(6), .TIMEOUT_CYC(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear_fault(clear_fault),
        .extr_bit   (extr_bit),
        .extr_valid (extr_valid),
        .extr_en    (extr_en),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef TRNG_CTRL_STATS_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    typedef struct packed {
        logic       start;
        logic       bit_v;
        logic       valid;
        logic       ready;
        logic       en;
        logic       rv;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(input logic s, input logic b, input logic v, input logic r,
                                 input logic en, input logic rv, input logic [7:0] d, input logic bz);
        vec_t x;
        x.start = s; x.bit_v = b; x.valid = v; x.ready = r;
        x.en = en; x.rv = rv; x.data = d; x.busy = bz;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        extr_bit   = b;
        extr_valid = 1'b1;
        tick();
        extr_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear_fault = 1'b0;
        extr_bit = 1'b0; extr_valid = 1'b0; rnd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_outputs", {extr_en, rnd_valid, rnd_data, busy, fault, fault_code}, 32'h0);

        // Stale valid in the first two enabled cycles must be ignored; then warm-up 1011, word A6.
        vecs[0]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[1]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[2]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[3]  = mkv(1, 0, 1, 1, 1, 0, 8'h00, 1);
        vecs[4]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[5]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[6]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[7]  = mkv(1, 0, 1, 1, 1, 0, 8'h00, 1);
        vecs[8]  = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[9]  = mkv(1, 0, 1, 1, 1, 0, 8'h00, 1);
        vecs[10] = mkv(1, 0, 1, 1, 1, 0, 8'h00, 1);
        vecs[11] = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[12] = mkv(1, 1, 1, 1, 1, 0, 8'h00, 1);
        vecs[13] = mkv(1, 0, 1, 1, 1, 1, 8'hA6, 1);
        vecs[14] = mkv(1, 0, 0, 1, 1, 0, 8'hA6, 1);
        for (int i = 0; i < 15; i++) begin
            start      = vecs[i].start;
            extr_bit   = vecs[i].bit_v;
            extr_valid = vecs[i].valid;
            rnd_ready  = vecs[i].ready;
            tick();
            check($sformatf("vec%0d", i), {fault, fault_code, extr_en, rnd_valid, rnd_data, busy},
                  {1'b0, 2'b00, vecs[i].en, vecs[i].rv, vecs[i].data, vecs[i].busy});
        end
        extr_valid = 1'b0;
        rnd_ready  = 1'b0;

        // Back-pressure: A6 loads, 5A completes into FULL.
        send_byte(8'hA6);
        check("a6_loaded", {rnd_valid, rnd_data, extr_en}, {1'b1, 8'hA6, 1'b1});
        send_byte(8'h5A);
        check("full_en", extr_en, 1'b0);
        check("full_busy", busy, 1'b1);
        check("full_hold_data", {rnd_valid, rnd_data}, {1'b1, 8'hA6});
        extr_bit = 1'b1; extr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("full_stale_en%0d", i), {extr_en, rnd_data}, {1'b0, 8'hA6});
        end
        extr_valid = 1'b0;
        rnd_ready = 1'b1;
        tick();
        check("full_release", {rnd_valid, rnd_data, extr_en}, {1'b1, 8'h5A, 1'b1});
        rnd_ready = 1'b0;
        tick();
        // A fresh word must contain exactly the next 8 bits, proving no stale bit was counted.
        send_byte(8'hC3);
        check("c3_full", {extr_en, rnd_valid, rnd_data}, {1'b0, 1'b1, 8'h5A});
        rnd_ready = 1'b1;
        tick();
        check("c3_release", {rnd_valid, rnd_data, extr_en}, {1'b1, 8'hC3, 1'b1});
        tick();
        check("c3_consumed", rnd_valid, 1'b0);
        rnd_ready = 1'b0;

        // Stop then restart; repetition fault lands on the bit that would complete a word.
        start = 1'b0;
        tick();
        check("stop_idle", {busy, extr_en, rnd_data}, {1'b0, 1'b0, 8'hC3});
        start = 1'b1;
        tick();
        check("restart_warmup", {busy, extr_en}, 2'b11);
        tick();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(0); send_bit(0); send_bit(1); send_bit(1);
        send_bit(1); send_bit(1); send_bit(1);
        check("rep_before", fault, 1'b0);
        send_bit(1);
        check("rep_fault", {fault, fault_code, rnd_valid, extr_en, busy}, {1'b1, FC_REP, 3'b000});
        tick();
        check("fault_ignores_start", {fault, busy, extr_en}, 3'b100);
        start = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("rep_cleared", {fault, fault_code, busy, extr_en}, 5'b0);

        // Starvation: no bits after warm-up for exactly 64 enabled cycles.
        start = 1'b1;
        tick(); tick();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        repeat (63) tick();
        check("to_before", {fault, extr_en}, 2'b01);
        tick();
        check("to_fault", {fault, fault_code, extr_en}, {1'b1, FC_TIMEOUT, 1'b0});
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("to_toggle", {fault, fault_code, busy, extr_en}, {1'b1, FC_TIMEOUT, 2'b00});
        start = 1'b0;
        tick();
        check("to_still", fault, 1'b1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("to_cleared", {fault, fault_code}, 3'b000);

        // Reset in the middle of filling a word.
        start = 1'b1;
        tick(); tick();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(1); send_bit(1); send_bit(0);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick(); tick();
        check("mid_rst", {extr_en, rnd_valid, rnd_data, busy, fault, fault_code}, 32'h0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("post_rst_idle", {extr_en, busy, rnd_valid}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_harvest_ctrl.md
Name: trng_harvest_ctrl

Overview:
Controller that sequences the Von Neumann debiasing extractor. It gates the extractor enable, discards a warm-up run of debiased bits, and packs accepted bits into WORD_W-bit random words. Words are delivered over a valid/ready interface. Runs continuous health tests (repetition count, starvation timeout) and latches a sticky fault. Sits between the extractor and the system-side random-word consumer.

Parameters:
WORD_W, 8, output word width in bits (2..32)
WARMUP_BITS, 16, accepted bits discarded after each start (0 = no warm-up)
REP_LIMIT, 32, consecutive identical accepted bits that trigger a repetition fault (2..255)
TIMEOUT_CYC, 1024, cycles with extr_en=1 and no accepted bit before a starvation fault

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  level; 1 = run harvesting, 0 = stop
clear_fault  in  1  pulse; leaves FAULT
extr_bit  in  1  extractor bit_out
extr_valid  in  1  extractor valid
extr_en  out  1  extractor enable
rnd_data  out  WORD_W  random word
rnd_valid  out  1  rnd_data holds an unconsumed word
rnd_ready  in  1  consumer accepts the word
busy  out  1  state is WARMUP, FILL or FULL
fault  out  1  sticky health fault
fault_code  out  2  01 = repetition, 10 = timeout, 00 = none

Behaviour:
- Reset: state IDLE, all outputs 0, shift register, bit counter, rep counter and timeout counter cleared, en_q=0.
- Accept rule: en_q <= extr_en every cycle. A bit is accepted when extr_valid && en_q. This is required because extractor valid holds its last value while disabled; stale valid with en_q=0 is ignored.
- IDLE: extr_en=0. If start=1, go to WARMUP (or FILL if WARMUP_BITS=0).
- WARMUP: extr_en=1. Accepted bits feed the health tests only. After WARMUP_BITS accepted bits, go to FILL.
- FILL: extr_en=1. Accepted bit shifts in at the LSB, shift left (first bit ends at MSB).
  - On the WORD_W-th bit, if the output register is free (rnd_valid=0, or rnd_valid && rnd_ready this cycle), load the word to rnd_data, set rnd_valid at the next edge, clear the bit count, stay in FILL.
  - Otherwise go to FULL.
- FULL: extr_en=0. On the rnd_valid && rnd_ready handshake, the shift word moves to rnd_data at that edge, rnd_valid stays 1, and the state returns to FILL.
- Handshake: a word transfers on the edge where rnd_valid && rnd_ready. rnd_data must stay stable while rnd_valid && !rnd_ready. rnd_valid clears after a transfer unless a new word loads on the same edge.
- start=0 in WARMUP/FILL/FULL: go to IDLE next edge. The partial or full shift word is discarded; the output register is kept. The warm-up is repeated on the next start.
- Repetition test: counts consecutive equal accepted bits (count=1 on a change) and saturates. When the count reaches REP_LIMIT, set fault=1, fault_code=01 and go to FAULT.
- Timeout: counter increments each cycle with extr_en=1 and no accept, and clears on accept or extr_en=0. At TIMEOUT_CYC: fault=1, fault_code=10, go to FAULT.
- Simultaneous events: fault beats word completion, so the word containing the failing bit is dropped. Repetition beats timeout.
- FAULT: extr_en=0, rnd_valid forced 0, shift register cleared, start ignored. clear_fault=1 clears fault, fault_code and all counters, then goes to IDLE.
- rst at any time returns to the reset state within one edge; an in-flight word is lost.

Optional Feature:
TRNG_CTRL_STATS_EN
- Defined: adds output word_cnt[15:0], incremented on each rnd handshake. Wraps 0xFFFF->0. Cleared by rst only.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package trng_pkg: state enum (IDLE, WARMUP, FILL, FULL, FAULT), fault-code constants (FC_NONE, FC_REP, FC_TIMEOUT), parameter defaults.
- Sub-module trng_rep_test: repetition counter taking accept and bit, returning rep_fail; clear on rst/clear_fault.
- Timeout counter and packer stay inline.

Test Plan:
- Bench settings: WORD_W=8, WARMUP_BITS=4, REP_LIMIT=6, TIMEOUT_CYC=64.
- Reset: rst high 2 cycles mid-FILL -> extr_en, rnd_valid, busy, fault all 0; state IDLE.
- Start, accept warm-up bits 1,0,1,1 then 1,0,1,0,0,1,1,0 with rnd_ready=1 -> rnd_data=8'hA6, rnd_valid=1 edge after 8th accept, one-cycle transfer.
- rnd_ready=0; words 0xA6 then 0x5A complete -> FULL, extr_en=0; rnd_ready=1 one cycle -> 0xA6 transfers, rnd_data=0x5A with rnd_valid=1, extr_en=1 next cycle.
- extr_valid held 1 for 5 cycles while extr_en=0 (in FULL) -> no bit counted; bit count unchanged.
- Six consecutive accepted 1s after warm-up -> fault=1, fault_code=01, rnd_valid=0, extr_en=0; clear_fault -> IDLE, fault=0.
- In FILL, no extr_valid for 64 cycles -> fault=1, fault_code=10; start toggling ignored until clear_fault.
